divide_unit: RTL and testbench

- Iterative RV32M divide/remainder unit, one level downstream of the register file read ports.
- Takes rs1/rs2 operands plus the destination register index, runs a restoring radix-2 division, and drives the register file write interface (rdAddress, rd, writeEnable) for one cycle when the result is ready.
- The control unit stalls on busy.

---
 rtl/divide_unit.sv | 147 ++++++++++++++
 tb/tb_divide_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/divide_unit.sv
// rtl/divide_unit.sv - iterative RV32M divide/remainder unit
// Restoring radix-2 division; result written back through the register file port.
module divide_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic [4:0]       rdAddressIn,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rd,
   output logic [4:0]       rdAddress,
   output logic             writeEnable
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] divisor;
   logic [4:0]       dest;
   logic             is_rem;
   logic             neg_q;
   logic             neg_r;

   logic             op_signed;
   logic             op_rem;
   logic             div_zero;
   logic             overflow;
   logic [WIDTH-1:0] abs1;
   logic [WIDTH-1:0] abs2;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   always_comb begin
      op_signed = (funct3 == 3'b100) || (funct3 == 3'b110);
      op_rem    = (funct3 == 3'b110) || (funct3 == 3'b111);
      div_zero  = (rs2 == '0);
      overflow  = op_signed && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
      abs1      = (op_signed && rs1[WIDTH-1]) ? -rs1 : rs1;
      abs2      = (op_signed && rs2[WIDTH-1]) ? -rs2 : rs2;
      shifted   = {rem, quo[WIDTH-1]};
      trial     = shifted - {1'b0, divisor};
   end

   // In FINISH, count is reused as a phase: 0 applies signs, 1 writes back.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         quo         <= '0;
         rem         <= '0;
         divisor     <= '0;
         dest        <= '0;
         is_rem      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rd          <= '0;
         rdAddress   <= '0;
         writeEnable <= 1'b0;
      end else begin
         done        <= 1'b0;
         writeEnable <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  busy    <= 1'b1;
                  dest    <= rdAddressIn;
                  is_rem  <= op_rem;
                  divisor <= abs2;
                  count   <= '0;
                  if (div_zero) begin
                     quo   <= '1;
                     rem   <= rs1;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= FINISH;
                  end else if (overflow) begin
                     quo   <= {1'b1, {(WIDTH-1){1'b0}}};
                     rem   <= '0;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= FINISH;
                  end else begin
                     quo   <= abs1;
                     rem   <= '0;
                     neg_q <= op_signed && (rs1[WIDTH-1] ^ rs2[WIDTH-1]);
                     neg_r <= op_signed && rs1[WIDTH-1];
                     state <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  if (!trial[WIDTH]) begin
                     rem <= trial[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= shifted[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
                  if (count == CW'(WIDTH - 1)) begin
                     count <= '0;
                     state <= FINISH;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
            end
            FINISH: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (count == '0) begin
                  quo   <= is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
                  count <= CW'(1);
               end else begin
                  rd          <= quo;
                  rdAddress   <= dest;
                  done        <= 1'b1;
                  writeEnable <= (dest != 5'd0);
                  busy        <= 1'b0;
                  count       <= '0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_divide_unit.sv
// tb/tb_divide_unit.sv - directed testbench for divide_unit
module tb_divide_unit;
   logic        clock;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [4:0]  rdAddressIn;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] rd;
   logic [4:0]  rdAddress;
   logic        writeEnable;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   divide_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .rdAddressIn(rdAddressIn), .flush(flush),
      .busy(busy), .done(done), .rd(rd), .rdAddress(rdAddress),
      .writeEnable(writeEnable)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr);
      @(negedge clock);
      funct3 = f; rs1 = a; rs2 = b; rdAddressIn = addr; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Returns with time just after the edge that raised done (or after 60 edges).
   task automatic wait_done(input int base, output int edges, output int wes);
      edges = base;
      wes = 0;
      while (edges < 60) begin
         @(posedge clock);
         edges++;
         #1;
         if (writeEnable) wes++;
         if (done) break;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; flush = 1'b0;
      funct3 = DIVU; rs1 = '0; rs2 = '0; rdAddressIn = '0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", writeEnable); end
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd); end
      checks++; if (rdAddress !== 5'd0) begin errors++; $display("FAIL reset_rdaddr got=%0d exp=0", rdAddress); end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_unsigned;
      int e, w;
      issue(DIVU, 32'd100, 32'd7, 5'd5);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy got=%0b exp=1", busy); end
      wait_done(0, e, w);
      checks++; if (e !== 34) begin errors++; $display("FAIL divu_latency got=%0d exp=34", e); end
      checks++; if (rd !== 32'd14) begin errors++; $display("FAIL divu_rd got=%h exp=%h", rd, 32'd14); end
      checks++; if (rdAddress !== 5'd5) begin errors++; $display("FAIL divu_rdaddr got=%0d exp=5", rdAddress); end
      checks++; if (writeEnable !== 1'b1 || w !== 1) begin errors++; $display("FAIL divu_we got=%0b/%0d exp=1/1", writeEnable, w); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_done got=%0b exp=0", busy); end
      @(posedge clock); #1;
      checks++; if (done !== 1'b0 || writeEnable !== 1'b0) begin errors++; $display("FAIL divu_pulse got=%0b%0b exp=00", done, writeEnable); end
      checks++; if (rd !== 32'd14) begin errors++; $display("FAIL divu_rd_hold got=%h exp=%h", rd, 32'd14); end
      issue(REMU, 32'd100, 32'd7, 5'd5);
      wait_done(0, e, w);
      checks++; if (rd !== 32'd2) begin errors++; $display("FAIL remu_rd got=%h exp=2", rd); end
      issue(DIVU, 32'hFFFFFFFF, 32'd2, 5'd3);
      wait_done(0, e, w);
      checks++; if (rd !== 32'h7FFFFFFF) begin errors++; $display("FAIL divu_big_rd got=%h exp=7fffffff", rd); end
   endtask

   task automatic test_signed;
      int e, w;
      issue(DIV, 32'hFFFFFFF9, 32'd2, 5'd4);
      wait_done(0, e, w);
      checks++; if (rd !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_rd got=%h exp=fffffffd", rd); end
      checks++; if (e !== 34) begin errors++; $display("FAIL div_latency got=%0d exp=34", e); end
      issue(REM, 32'hFFFFFFF9, 32'd2, 5'd4);
      wait_done(0, e, w);
      checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg_rd got=%h exp=ffffffff", rd); end
      issue(DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd4);
      wait_done(0, e, w);
      checks++; if (rd !== 32'd3) begin errors++; $display("FAIL div_negneg_rd got=%h exp=3", rd); end
   endtask

   task automatic test_special;
      int e, w;
      issue(DIVU, 32'd5, 32'd0, 5'd8);
      wait_done(0, e, w);
      checks++; if (e !== 2) begin errors++; $display("FAIL divzero_latency got=%0d exp=2", e); end
      checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL divzero_rd got=%h exp=ffffffff", rd); end
      issue(REMU, 32'd5, 32'd0, 5'd8);
      wait_done(0, e, w);
      checks++; if (rd !== 32'd5) begin errors++; $display("FAIL remzero_rd got=%h exp=5", rd); end
      issue(DIV, 32'h80000000, 32'hFFFFFFFF, 5'd9);
      wait_done(0, e, w);
      checks++; if (e !== 2) begin errors++; $display("FAIL ovf_latency got=%0d exp=2", e); end
      checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL ovf_div_rd got=%h exp=80000000", rd); end
      issue(REM, 32'h80000000, 32'hFFFFFFFF, 5'd9);
      wait_done(0, e, w);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL ovf_rem_rd got=%h exp=0", rd); end
   endtask

   task automatic test_zero_dest;
      int e, w;
      issue(DIVU, 32'd9, 32'd3, 5'd0);
      wait_done(0, e, w);
      checks++; if (done !== 1'b1 || rd !== 32'd3) begin errors++; $display("FAIL x0_done_rd got=%0b/%h exp=1/3", done, rd); end
      checks++; if (w !== 0) begin errors++; $display("FAIL x0_we got=%0d exp=0", w); end
   endtask

   task automatic test_back_to_back;
      int e, w;
      issue(DIVU, 32'd100, 32'd7, 5'd5);
      e = 0;
      repeat (4) begin @(posedge clock); e++; end
      @(negedge clock);
      rs1 = 32'd50; rs2 = 32'd3; rdAddressIn = 5'd12; start = 1'b1;
      @(posedge clock); e++;
      #1 start = 1'b0;
      wait_done(e, e, w);
      checks++; if (e !== 34) begin errors++; $display("FAIL ignore_latency got=%0d exp=34", e); end
      checks++; if (rd !== 32'd14 || rdAddress !== 5'd5) begin errors++; $display("FAIL ignore_rd got=%h/%0d exp=e/5", rd, rdAddress); end
      funct3 = REMU; rs1 = 32'd100; rs2 = 32'd7; rdAddressIn = 5'd6; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%0b exp=1", busy); end
      wait_done(0, e, w);
      checks++; if (e !== 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", e); end
      checks++; if (rd !== 32'd2 || rdAddress !== 5'd6) begin errors++; $display("FAIL b2b_rd got=%h/%0d exp=2/6", rd, rdAddress); end
   endtask

   task automatic test_flush;
      int d, w;
      issue(DIVU, 32'd1000, 32'd7, 5'd7);
      repeat (10) @(posedge clock);
      @(negedge clock);
      flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%0b exp=0", busy); end
      d = 0; w = 0;
      repeat (40) begin
         @(negedge clock);
         if (done) d++;
         if (writeEnable) w++;
      end
      checks++; if (d !== 0 || w !== 0) begin errors++; $display("FAIL flush_pulses got=%0d/%0d exp=0/0", d, w); end
      checks++; if (rd !== 32'd2 || rdAddress !== 5'd6) begin errors++; $display("FAIL flush_rd got=%h/%0d exp=2/6", rd, rdAddress); end
      @(negedge clock);
      flush = 1'b1; start = 1'b1; funct3 = DIVU; rs1 = 32'd9; rs2 = 32'd3; rdAddressIn = 5'd1;
      @(posedge clock);
      #1 flush = 1'b0; start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_reset_mid;
      int d, w;
      issue(DIVU, 32'd1000, 32'd7, 5'd11);
      repeat (15) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || writeEnable !== 1'b0) begin
         errors++; $display("FAIL amid_ctrl got=%0b%0b%0b exp=000", busy, done, writeEnable); end
      checks++; if (rd !== 32'd0 || rdAddress !== 5'd0) begin
         errors++; $display("FAIL amid_data got=%h/%0d exp=0/0", rd, rdAddress); end
      @(negedge clock);
      reset = 1'b1;
      d = 0; w = 0;
      repeat (40) begin
         @(negedge clock);
         if (done) d++;
         if (writeEnable) w++;
      end
      checks++; if (d !== 0 || w !== 0) begin errors++; $display("FAIL amid_pulses got=%0d/%0d exp=0/0", d, w); end
   endtask

   initial begin
      test_reset;
      test_unsigned;
      test_signed;
      test_special;
      test_zero_dest;
      test_back_to_back;
      test_flush;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
